// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one memory port between a CPU and a program loader.
module mem_port_arbiter #(
   parameter int MEM_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_ack,
   input  logic        ldr_req,
   input  logic        ldr_we,
   input  logic [31:0] ldr_addr,
   input  logic [31:0] ldr_wdata,
   output logic [31:0] ldr_rdata,
   output logic        ldr_ack,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        grant_ldr
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   state_t state, state_nx;
   logic last_grant, win_ldr, win_we, pick_ldr, start, access_done;
   logic [2:0] lat_cnt;
   // on a tie the port that did not win last time gets the memory
   assign pick_ldr = ldr_req & (~cpu_req | ~last_grant);
   assign start = (state == IDLE) & (cpu_req | ldr_req);
   assign access_done = win_we | (lat_cnt == 3'(MEM_LAT));
   always_comb begin
      state_nx = state;
      if (start) state_nx = ACCESS;
      else if (state == ACCESS && access_done) state_nx = RESP;
      else if (state == RESP) state_nx = IDLE;
      mem_en = (state == ACCESS) && (lat_cnt == 3'd0);
      mem_we = mem_en && win_we;
      cpu_ack = (state == RESP) && !win_ldr;
      ldr_ack = (state == RESP) && win_ldr;
      grant_ldr = (state != IDLE) && win_ldr;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         last_grant <= 1'b1;
         lat_cnt <= 3'd0;
         win_ldr <= 1'b0;
         win_we <= 1'b0;
         mem_addr <= 32'h0;
         mem_wdata <= 32'h0;
         cpu_rdata <= 32'h0;
         ldr_rdata <= 32'h0;
      end else begin
         state <= state_nx;
         if (start) begin
            win_ldr <= pick_ldr;
            win_we <= pick_ldr ? ldr_we : cpu_we;
            mem_addr <= pick_ldr ? ldr_addr : cpu_addr;
            mem_wdata <= pick_ldr ? ldr_wdata : cpu_wdata;
            lat_cnt <= 3'd0;
         end else if (state == ACCESS) begin
            lat_cnt <= lat_cnt + 3'd1;
         end
         // read data is valid in the last ACCESS cycle only
         if (state == ACCESS && !win_we && access_done) begin
            if (win_ldr) ldr_rdata <= mem_rdata;
            else cpu_rdata <= mem_rdata;
         end
         if (state == RESP) last_grant <= win_ldr;
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench with a transaction-level model for MEM_LAT=1 and literal checks for MEM_LAT=4.
module tb_mem_port_arbiter;
   localparam int L = 1;
   logic clk = 0, rst = 1, armed = 0;
   always #5 clk = ~clk;
   logic cpu_req = 0, cpu_we = 0, ldr_req = 0, ldr_we = 0;
   logic [31:0] cpu_addr = 0, cpu_wdata = 0, ldr_addr = 0, ldr_wdata = 0;
   logic [31:0] cpu_rdata, ldr_rdata, mem_addr, mem_wdata, mem_rdata;
   logic cpu_ack, ldr_ack, mem_en, mem_we, grant_ldr;
   logic c4_req = 0, c4_we = 0, c4_ack, l4_ack, m4_en, m4_we, g4;
   logic [31:0] c4_addr = 0, c4_wdata = 0, c4_rdata, l4_rdata, m4_addr, m4_wdata, m4_rdata;
   int checks = 0, failures = 0;

   mem_port_arbiter #(.MEM_LAT(1)) dut (
      .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .ldr_req(ldr_req),
      .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_rdata(ldr_rdata),
      .ldr_ack(ldr_ack), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .grant_ldr(grant_ldr));

   mem_port_arbiter #(.MEM_LAT(4)) dut4 (
      .clk(clk), .rst(rst), .cpu_req(c4_req), .cpu_we(c4_we), .cpu_addr(c4_addr),
      .cpu_wdata(c4_wdata), .cpu_rdata(c4_rdata), .cpu_ack(c4_ack), .ldr_req(1'b0),
      .ldr_we(1'b0), .ldr_addr(32'h0), .ldr_wdata(32'h0), .ldr_rdata(l4_rdata),
      .ldr_ack(l4_ack), .mem_en(m4_en), .mem_we(m4_we), .mem_addr(m4_addr),
      .mem_wdata(m4_wdata), .mem_rdata(m4_rdata), .grant_ldr(g4));

   // memories: data appears MEM_LAT cycles after the enable cycle, garbage otherwise
   logic [31:0] mem1 [0:63];
   logic [31:0] mem4 [0:63];
   logic [31:0] m_mem [0:63];
   logic [31:0] p1;
   logic [31:0] p4 [0:3];
   assign mem_rdata = p1;
   assign m4_rdata = p4[3];
   always @(posedge clk) begin
      if (mem_en && mem_we) mem1[mem_addr[7:2]] <= mem_wdata;
      p1 <= (mem_en && !mem_we) ? mem1[mem_addr[7:2]] : 32'hBAD0BAD0;
      if (m4_en && m4_we) mem4[m4_addr[7:2]] <= m4_wdata;
      p4[0] <= (m4_en && !m4_we) ? mem4[m4_addr[7:2]] : 32'hBAD0BAD0;
      for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
   end

   // transaction model: age counts cycles since the request was sampled in idle
   logic m_busy, m_ldr, m_we, m_last;
   logic [31:0] m_addr, m_wdata, m_crd, m_lrd;
   int m_age, m_done;
   logic m_pick;
   assign m_pick = (cpu_req && ldr_req) ? !m_last : ldr_req;
   assign m_done = m_we ? 2 : L + 2;
   always @(posedge clk) begin
      if (rst) begin
         m_busy <= 0; m_last <= 1; m_we <= 0; m_ldr <= 0;
         m_addr <= 0; m_wdata <= 0; m_crd <= 0; m_lrd <= 0; m_age <= 0;
      end else if (m_busy) begin
         if (m_we && m_age == 1) m_mem[m_addr[7:2]] <= m_wdata;
         if (!m_we && m_age == L + 1) begin
            if (m_ldr) m_lrd <= m_mem[m_addr[7:2]];
            else m_crd <= m_mem[m_addr[7:2]];
         end
         if (m_age == m_done) begin m_busy <= 0; m_last <= m_ldr; end
         m_age <= m_age + 1;
      end else if (cpu_req || ldr_req) begin
         m_busy <= 1; m_age <= 1; m_ldr <= m_pick;
         m_we <= m_pick ? ldr_we : cpu_we;
         m_addr <= m_pick ? ldr_addr : cpu_addr;
         m_wdata <= m_pick ? ldr_wdata : cpu_wdata;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) if (armed) begin
      chk("mem_en", mem_en, m_busy && m_age == 1);
      chk("mem_we", mem_we, m_busy && m_age == 1 && m_we);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("cpu_ack", cpu_ack, m_busy && m_age == m_done && !m_ldr);
      chk("ldr_ack", ldr_ack, m_busy && m_age == m_done && m_ldr);
      chk("grant_ldr", grant_ldr, m_busy && m_ldr);
      chk("cpu_rdata", cpu_rdata, m_crd);
      chk("ldr_rdata", ldr_rdata, m_lrd);
   end

   task automatic xact(input string nm, input bit ldr, input bit we, input logic [31:0] a,
                       input logic [31:0] d, input int exp_lat);
      int n = 0, en_at = 0, en_cnt = 0;
      logic ew = 0, got = 0;
      logic [31:0] ea = 0;
      @(negedge clk);
      if (ldr) begin ldr_req = 1; ldr_we = we; ldr_addr = a; ldr_wdata = d; end
      else begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
      while (!got && n < 30) begin
         @(negedge clk);
         n++;
         if (mem_en) begin
            en_cnt++;
            if (en_at == 0) begin en_at = n; ew = mem_we; ea = mem_addr; end
         end
         got = ldr ? ldr_ack : cpu_ack;
      end
      cpu_req = 0; ldr_req = 0;
      chk({nm, ".lat"}, n, exp_lat);
      chk({nm, ".en_at"}, en_at, 1);
      chk({nm, ".en_cnt"}, en_cnt, 1);
      chk({nm, ".we"}, ew, we);
      chk({nm, ".addr"}, ea, a);
   endtask

   task automatic x4(input string nm, input bit we, input logic [31:0] a, input logic [31:0] d,
                     input int exp_lat);
      int n = 0, en = 0;
      @(negedge clk);
      c4_req = 1; c4_we = we; c4_addr = a; c4_wdata = d;
      while (!c4_ack && n < 30) begin
         @(negedge clk);
         n++;
         en += int'(m4_en);
      end
      c4_req = 0;
      chk({nm, ".lat"}, n, exp_lat);
      chk({nm, ".en_cnt"}, en, 1);
   endtask

   initial begin
      int n, k;
      for (int i = 0; i < 64; i++) begin
         mem1[i] = 32'hA5000000 + i;
         mem4[i] = 32'hA5000000 + i;
         m_mem[i] = 32'hA5000000 + i;
      end
      mem1[4] = 32'hDEADBEEF; mem4[4] = 32'hDEADBEEF; m_mem[4] = 32'hDEADBEEF;
      repeat (2) @(negedge clk);
      armed = 1;
      chk("rst.mem_en", mem_en, 0);
      chk("rst.cpu_ack", cpu_ack, 0);
      chk("rst.ldr_ack", ldr_ack, 0);
      chk("rst.grant_ldr", grant_ldr, 0);
      chk("rst.mem_addr", mem_addr, 0);
      chk("rst.cpu_rdata", cpu_rdata, 0);
      chk("rst.ldr_rdata", ldr_rdata, 0);
      // reset in the second ACCESS cycle of a cpu read
      @(negedge clk);
      rst = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
      @(negedge clk);
      chk("abort.en_T1", mem_en, 1);
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk("abort.cpu_ack", cpu_ack, 0);
      chk("abort.cpu_rdata", cpu_rdata, 0);
      chk("abort.mem_en", mem_en, 0);
      n = 0;
      while (!cpu_ack && n < 30) begin @(negedge clk); n++; end
      cpu_req = 0;
      chk("abort.restart_lat", n, 3);
      chk("abort.restart_rdata", cpu_rdata, 32'hDEADBEEF);
      xact("cpu_rd10", 0, 0, 32'h10, 32'h0, 3);
      chk("cpu_rd10.data", cpu_rdata, 32'hDEADBEEF);
      xact("ldr_wr20", 1, 1, 32'h20, 32'h12345678, 2);
      chk("ldr_wr20.ldr_rdata", ldr_rdata, 0);
      xact("cpu_rd20", 0, 0, 32'h20, 32'h0, 3);
      chk("cpu_rd20.data", cpu_rdata, 32'h12345678);
      chk("cpu_rd20.ldr_rdata", ldr_rdata, 0);
      xact("cpu_wr30", 0, 1, 32'h30, 32'hCAFEF00D, 2);
      chk("cpu_wr30.cpu_rdata", cpu_rdata, 32'h12345678);
      xact("ldr_rd30", 1, 0, 32'h30, 32'h0, 3);
      chk("ldr_rd30.data", ldr_rdata, 32'hCAFEF00D);
      chk("ldr_rd30.cpu_rdata", cpu_rdata, 32'h12345678);
      xact("ldr_rd10", 1, 0, 32'h10, 32'h0, 3);
      chk("ldr_rd10.data", ldr_rdata, 32'hDEADBEEF);
      // both read continuously from reset: cpu, ldr, cpu, ldr every 4 cycles
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h30;
      ldr_req = 1; ldr_we = 0; ldr_addr = 32'h20;
      n = 0; k = 0;
      while (k < 4 && n < 40) begin
         @(negedge clk);
         n++;
         chk("rr.overlap", cpu_ack & ldr_ack, 0);
         if (cpu_ack || ldr_ack) begin
            chk($sformatf("rr.who%0d", k), ldr_ack, 32'(k % 2));
            chk($sformatf("rr.at%0d", k), n, 3 + 4 * k);
            chk($sformatf("rr.grant%0d", k), grant_ldr, ldr_ack);
            k++;
         end
      end
      cpu_req = 0; ldr_req = 0;
      chk("rr.count", k, 4);
      chk("rr.cpu_rdata", cpu_rdata, 32'hCAFEF00D);
      chk("rr.ldr_rdata", ldr_rdata, 32'h12345678);
      x4("l4_rd10", 0, 32'h10, 32'h0, 6);
      chk("l4_rd10.data", c4_rdata, 32'hDEADBEEF);
      x4("l4_wr14", 1, 32'h14, 32'h55AA55AA, 2);
      chk("l4_wr14.cpu_rdata", c4_rdata, 32'hDEADBEEF);
      x4("l4_rd14", 0, 32'h14, 32'h0, 6);
      chk("l4_rd14.data", c4_rdata, 32'h55AA55AA);
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 1: memory read latency in cycles from the mem_en edge to valid mem_rdata; legal range 1..4.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 cpu_req, cpu_we  in  1 each  CPU (main controller) access request; write enable.
REQ-005 cpu_addr, cpu_wdata  in  32 each  CPU byte address; CPU write data.
REQ-006 cpu_rdata  out  32  registered CPU read data; cpu_ack  out  1  one-cycle CPU completion pulse.
REQ-007 ldr_req, ldr_we  in  1 each  program-loader request; write enable.
REQ-008 ldr_addr, ldr_wdata  in  32 each  loader address; loader write data.
REQ-009 ldr_rdata  out  32  registered loader read data; ldr_ack  out  1  one-cycle loader completion pulse.
REQ-010 mem_en, mem_we  out  1 each  unified memory enable; write strobe.
REQ-011 mem_addr, mem_wdata  out  32 each  registered memory address; registered write data.
REQ-012 mem_rdata  in  32  memory read data, valid MEM_LAT cycles after the mem_en cycle.
REQ-013 grant_ldr  out  1  high while the loader owns the memory port (ACCESS or RESP).

Function
REQ-014 The FSM SHALL have the states IDLE, ACCESS and RESP.
REQ-015 In IDLE with any request pending, the arbiter SHALL pick a winner, latch its we/addr/wdata into mem_we/mem_addr/mem_wdata registers and go to ACCESS at the next edge.
REQ-016 A single request SHALL win outright; on a tie, the port not granted last SHALL win (round-robin via a last_grant register).
REQ-017 mem_en SHALL be high only in the first ACCESS cycle; mem_we SHALL be high only in that cycle and only for writes.
REQ-018 For a write, ACCESS SHALL last 1 cycle; for a read, it SHALL last MEM_LAT+1 cycles, counted by a latency counter cleared on ACCESS entry.
REQ-019 For a read, mem_rdata SHALL be captured into the winner's rdata register at the end of the last ACCESS cycle; the other port's rdata SHALL be unchanged.
REQ-020 In RESP (exactly one cycle), the winner's ack SHALL be high, last_grant SHALL update to the winner, and the FSM SHALL return to IDLE.
REQ-021 Total latency from request-sampled cycle to ack: write 2 cycles; read MEM_LAT+2 cycles.
REQ-022 Requests SHALL be sampled only in IDLE; requests arriving in ACCESS/RESP SHALL wait, not be dropped.
REQ-023 A requester SHALL hold req and its fields until ack, and SHALL deassert req by the edge ending its ack cycle unless it wants another access; req still high in the following IDLE SHALL start a new transaction.
REQ-024 Back-to-back, both requesting: grants SHALL alternate cpu, ldr, cpu, ... with one IDLE cycle between transactions.
REQ-025 rdata outputs SHALL hold their last captured value indefinitely; writes SHALL never modify them.
REQ-026 Both acks SHALL never be high in the same cycle; mem_en SHALL never be high outside ACCESS.

Reset
REQ-027 With rst high at an edge, the block SHALL reset as follows: state IDLE; last_grant = ldr, so the first tie goes to the CPU; latency counter 0; mem_en, mem_we, cpu_ack, ldr_ack and grant_ldr 0; mem_addr, mem_wdata, cpu_rdata and ldr_rdata 0x00000000.
REQ-028 Reset mid-transaction SHALL abort it with no ack and no rdata update; a request held through reset SHALL be re-arbitrated from IDLE.

Verification
REQ-029 With MEM_LAT=1, cpu read of 0x10 where memory holds 0xDEADBEEF: mem_en at T1, cpu_ack and cpu_rdata=0xDEADBEEF at T3.
REQ-030 ldr write of 0x20 with data 0x12345678: mem_en=mem_we=1, mem_addr=0x20 at T1; ldr_ack at T2; a following cpu read of 0x20 returns 0x12345678.
REQ-031 Both request reads continuously after reset: grant order cpu, ldr, cpu, ldr; acks never overlap; grant_ldr matches the loader transactions.
REQ-032 With MEM_LAT=4, a read acks at T6; mem_en is high for exactly 1 cycle.
REQ-033 rst asserted in the second ACCESS cycle of a read: no ack, cpu_rdata stays 0, mem_en 0; the held request restarts and completes after rst drops.
